// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: two-stage store buffer with byte-granular store-to-load forwarding.
module store_buffer_fwd #(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 8,
  parameter int unsigned PLEN         = 56,
  parameter int unsigned DATA_WIDTH   = 64,
  localparam int unsigned BE_W        = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [PLEN-1:0]       paddr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [1:0]            size_i,
  input  logic                  commit_i,
  output logic                  commit_ready_o,
  input  logic                  ld_valid_i,
  input  logic [PLEN-1:0]       ld_paddr_i,
  input  logic [BE_W-1:0]       ld_be_i,
  output logic                  ld_fwd_valid_o,
  output logic [DATA_WIDTH-1:0] ld_fwd_data_o,
  output logic                  ld_stall_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [PLEN-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_W-1:0]       mem_be_o,
  output logic [1:0]            mem_size_o,
  output logic                  no_st_pending_o,
  output logic                  empty_o
);
  localparam int unsigned SP  = $clog2(DEPTH_SPEC);
  localparam int unsigned CP  = $clog2(DEPTH_COMMIT);
  localparam int unsigned OFF = $clog2(BE_W);
  localparam logic [SP:0] SPEC_FULL   = (SP+1)'(DEPTH_SPEC);
  localparam logic [CP:0] COMMIT_FULL = (CP+1)'(DEPTH_COMMIT);
  typedef struct packed {
    logic [PLEN-1:0]       addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
    logic [1:0]            size;
  } entry_t;
  entry_t spec_q [DEPTH_SPEC];
  entry_t spec_d [DEPTH_SPEC];
  entry_t commit_q [DEPTH_COMMIT];
  entry_t commit_d [DEPTH_COMMIT];
  logic [SP-1:0] spec_wptr_q, spec_wptr_d, spec_rptr_q, spec_rptr_d;
  logic [CP-1:0] commit_wptr_q, commit_wptr_d, commit_rptr_q, commit_rptr_d;
  logic [SP:0]   cnt_spec_q, cnt_spec_d;
  logic [CP:0]   cnt_commit_q, cnt_commit_d;
  logic push, commit, grant, push_ovl, hit, hit_full;
  logic [DATA_WIDTH-1:0] hit_data;
  entry_t head;
  function automatic logic ovl(input entry_t e);
    return e.addr[PLEN-1:OFF] == ld_paddr_i[PLEN-1:OFF] && |(e.be & ld_be_i);
  endfunction
  function automatic logic cov(input entry_t e);
    return (e.be & ld_be_i) == ld_be_i;
  endfunction
  assign ready_o         = cnt_spec_q < SPEC_FULL;
  assign commit_ready_o  = cnt_commit_q < COMMIT_FULL;
  assign no_st_pending_o = cnt_commit_q == '0;
  assign empty_o         = no_st_pending_o && cnt_spec_q == '0;
  assign push   = valid_i && ready_o && !flush_i;
  assign commit = commit_i && cnt_spec_q != '0 && commit_ready_o && !flush_i;
  assign grant  = mem_req_o && mem_gnt_i;
  assign head        = commit_q[commit_rptr_q];
  assign mem_req_o   = !no_st_pending_o;
  assign mem_addr_o  = mem_req_o ? head.addr : '0;
  assign mem_wdata_o = mem_req_o ? head.data : '0;
  assign mem_be_o    = mem_req_o ? head.be : '0;
  assign mem_size_o  = mem_req_o ? head.size : '0;
  always_comb begin
    spec_d        = spec_q;
    commit_d      = commit_q;
    spec_wptr_d   = spec_wptr_q;
    spec_rptr_d   = spec_rptr_q;
    commit_wptr_d = commit_wptr_q;
    commit_rptr_d = commit_rptr_q + CP'(grant);
    if (push) begin
      spec_d[spec_wptr_q] = '{paddr_i, data_i, be_i, size_i};
      spec_wptr_d = spec_wptr_q + 1'b1;
    end
    if (commit) begin
      commit_d[commit_wptr_q] = spec_q[spec_rptr_q];
      spec_rptr_d   = spec_rptr_q + 1'b1;
      commit_wptr_d = commit_wptr_q + 1'b1;
    end
    if (flush_i) spec_wptr_d = spec_rptr_q;
    cnt_spec_d   = flush_i ? '0 : cnt_spec_q + (SP+1)'(push) - (SP+1)'(commit);
    cnt_commit_d = cnt_commit_q + (CP+1)'(commit) - (CP+1)'(grant);
  end
  // Walk oldest to youngest so the last overlapping entry seen is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_full = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH_COMMIT; k++)
      if ((CP+1)'(k) < cnt_commit_q && ovl(commit_q[commit_rptr_q + CP'(k)])) begin
        hit      = 1'b1;
        hit_full = cov(commit_q[commit_rptr_q + CP'(k)]);
        hit_data = commit_q[commit_rptr_q + CP'(k)].data;
      end
    for (int k = 0; k < DEPTH_SPEC; k++)
      if ((SP+1)'(k) < cnt_spec_q && ovl(spec_q[spec_rptr_q + SP'(k)])) begin
        hit      = 1'b1;
        hit_full = cov(spec_q[spec_rptr_q + SP'(k)]);
        hit_data = spec_q[spec_rptr_q + SP'(k)].data;
      end
  end
  assign push_ovl = valid_i && ready_o && paddr_i[PLEN-1:OFF] == ld_paddr_i[PLEN-1:OFF] && |(be_i & ld_be_i);
  assign ld_fwd_valid_o = ld_valid_i && hit && hit_full && !push_ovl;
  assign ld_stall_o     = ld_valid_i && ((hit && !hit_full) || push_ovl);
  assign ld_fwd_data_o  = ld_fwd_valid_o ? hit_data : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_q        <= '{default: '0};
      commit_q      <= '{default: '0};
      spec_wptr_q   <= '0;
      spec_rptr_q   <= '0;
      commit_wptr_q <= '0;
      commit_rptr_q <= '0;
      cnt_spec_q    <= '0;
      cnt_commit_q  <= '0;
    end else begin
      spec_q        <= spec_d;
      commit_q      <= commit_d;
      spec_wptr_q   <= spec_wptr_d;
      spec_rptr_q   <= spec_rptr_d;
      commit_wptr_q <= commit_wptr_d;
      commit_rptr_q <= commit_rptr_d;
      cnt_spec_q    <= cnt_spec_d;
      cnt_commit_q  <= cnt_commit_d;
    end
  end
  commit_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_i |-> (cnt_spec_q != '0 && commit_ready_o && !flush_i));
endmodule

// File: tb/tb_store_buffer_fwd.sv
// tb_store_buffer_fwd: directed and random checks of store_buffer_fwd against a queue-based model.
module tb_store_buffer_fwd;
  logic clk, rst, flush_i, valid_i, commit_i, ld_valid_i, mem_gnt_i;
  logic [55:0] paddr_i, ld_paddr_i;
  logic [63:0] data_i;
  logic [7:0]  be_i, ld_be_i;
  logic [1:0]  size_i;
  logic ready_o, commit_ready_o, ld_fwd_valid_o, ld_stall_o, mem_req_o, no_st_pending_o, empty_o;
  logic [63:0] ld_fwd_data_o, mem_wdata_o;
  logic [55:0] mem_addr_o;
  logic [7:0]  mem_be_o;
  logic [1:0]  mem_size_o;
  int n_pass = 0, n_chk = 0;
  typedef struct {
    logic [55:0] a;
    logic [63:0] d;
    logic [7:0]  be;
    logic [1:0]  sz;
  } st_t;
  st_t spec_m[$], com_m[$];
  store_buffer_fwd dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i),
    .commit_i(commit_i), .commit_ready_o(commit_ready_o),
    .ld_valid_i(ld_valid_i), .ld_paddr_i(ld_paddr_i), .ld_be_i(ld_be_i),
    .ld_fwd_valid_o(ld_fwd_valid_o), .ld_fwd_data_o(ld_fwd_data_o), .ld_stall_o(ld_stall_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_size_o(mem_size_o),
    .no_st_pending_o(no_st_pending_o), .empty_o(empty_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Reference: scan every buffered store from youngest to oldest, first overlap decides.
  function automatic void exp_fwd(output logic fv, output logic st, output logic [63:0] fd);
    bit found = 0;
    fv = 0; st = 0; fd = '0;
    if (!ld_valid_i) return;
    for (int i = spec_m.size() - 1; i >= 0 && !found; i--)
      if ((spec_m[i].a >> 3) == (ld_paddr_i >> 3) && (spec_m[i].be & ld_be_i) != 0) begin
        found = 1;
        if ((spec_m[i].be & ld_be_i) == ld_be_i) begin fv = 1; fd = spec_m[i].d; end else st = 1;
      end
    for (int i = com_m.size() - 1; i >= 0 && !found; i--)
      if ((com_m[i].a >> 3) == (ld_paddr_i >> 3) && (com_m[i].be & ld_be_i) != 0) begin
        found = 1;
        if ((com_m[i].be & ld_be_i) == ld_be_i) begin fv = 1; fd = com_m[i].d; end else st = 1;
      end
    if (valid_i && spec_m.size() < 4 && (paddr_i >> 3) == (ld_paddr_i >> 3) && (be_i & ld_be_i) != 0) begin
      st = 1; fv = 0; fd = '0;
    end
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_m.delete();
      com_m.delete();
    end else begin
      bit p, c, g;
      p = valid_i && spec_m.size() < 4 && !flush_i;
      c = commit_i && spec_m.size() > 0 && com_m.size() < 8 && !flush_i;
      g = mem_gnt_i && com_m.size() > 0;
      if (g) void'(com_m.pop_front());
      if (c) com_m.push_back(spec_m.pop_front());
      if (flush_i) spec_m.delete();
      else if (p) spec_m.push_back('{paddr_i, data_i, be_i, size_i});
    end
  end
  always @(negedge clk) if (!rst) begin
    logic fv, st;
    logic [63:0] fd;
    exp_fwd(fv, st, fd);
    chk("ready", ready_o, spec_m.size() < 4);
    chk("commit_ready", commit_ready_o, com_m.size() < 8);
    chk("mem_req", mem_req_o, com_m.size() > 0);
    chk("mem_addr", mem_addr_o, com_m.size() > 0 ? com_m[0].a : 56'h0);
    chk("mem_wdata", mem_wdata_o, com_m.size() > 0 ? com_m[0].d : 64'h0);
    chk("mem_be", mem_be_o, com_m.size() > 0 ? com_m[0].be : 8'h0);
    chk("mem_size", mem_size_o, com_m.size() > 0 ? com_m[0].sz : 2'h0);
    chk("no_st_pending", no_st_pending_o, com_m.size() == 0);
    chk("empty", empty_o, com_m.size() == 0 && spec_m.size() == 0);
    chk("fwd_valid", ld_fwd_valid_o, fv);
    chk("fwd_data", ld_fwd_data_o, fd);
    chk("stall", ld_stall_o, st);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    flush_i = 0; valid_i = 0; commit_i = 0; ld_valid_i = 0; mem_gnt_i = 0;
    paddr_i = '0; data_i = '0; be_i = '0; size_i = '0; ld_paddr_i = '0; ld_be_i = '0;
  endtask
  task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
    idle();
    valid_i = 1; paddr_i = a; data_i = d; be_i = be; size_i = 2'd3;
    cyc();
    idle();
  endtask
  task automatic load(input logic [55:0] a, input logic [7:0] be);
    ld_valid_i = 1; ld_paddr_i = a; ld_be_i = be;
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    idle();
    while ((spec_m.size() > 0 || com_m.size() > 0) && n < 200) begin
      commit_i = spec_m.size() > 0 && com_m.size() < 8;
      mem_gnt_i = 1;
      cyc();
      n++;
    end
    idle();
    @(negedge clk);
    chk("drain_empty", empty_o, 1);
    cyc();
  endtask
  initial begin
    int i, n;
    rst = 1;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_commit_ready", commit_ready_o, 1);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_no_st", no_st_pending_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_fwd", {ld_fwd_valid_o, ld_stall_o}, 0);
    #1 rst = 0;
    cyc();
    push(56'h1000, 64'h1122334455667788, 8'hFF);
    commit_i = 1; cyc(); idle();
    repeat (3) begin
      @(negedge clk);
      chk("drain_req_held", mem_req_o, 1);
      chk("drain_addr_held", mem_addr_o, 56'h1000);
      cyc();
    end
    mem_gnt_i = 1;
    @(negedge clk);
    chk("drain_req_gnt", mem_req_o, 1);
    chk("drain_wdata", mem_wdata_o, 64'h1122334455667788);
    cyc(); idle();
    @(negedge clk);
    chk("drain_no_st", no_st_pending_o, 1);
    chk("drain_empty1", empty_o, 1);
    cyc();
    for (int k = 0; k < 4; k++) push(56'h100 + 56'(8 * k), 64'(k), 8'hFF);
    @(negedge clk); chk("full_ready", ready_o, 0);
    push(56'h7777, 64'h55, 8'hFF);
    @(negedge clk); chk("drop_ready", ready_o, 0);
    commit_i = 1; cyc(); idle();
    @(negedge clk); chk("commit_frees", ready_o, 1);
    valid_i = 1; paddr_i = 56'h120; be_i = 8'hFF; commit_i = 1; cyc(); idle();
    @(negedge clk); chk("push_commit_ready", ready_o, 1);
    push(56'h128, 64'h9, 8'hFF);
    @(negedge clk); chk("refull_ready", ready_o, 0);
    drain();
    for (int k = 0; k < 3; k++) push(56'h200 + 56'(8 * k), 64'(k), 8'hFF);
    flush_i = 1; valid_i = 1; paddr_i = 56'h218; be_i = 8'hFF; cyc(); idle();
    @(negedge clk); chk("flush_empty", empty_o, 1);
    push(56'h5000, 64'h5, 8'hF0);
    commit_i = 1; cyc(); idle();
    @(negedge clk); chk("post_flush_addr", mem_addr_o, 56'h5000);
    drain();
    i = 0; n = 0;
    while (i < 20 && n < 200) begin
      idle();
      if (spec_m.size() < 4) begin
        valid_i = 1; paddr_i = 56'h6000 + 56'(8 * i); data_i = 64'(i); be_i = 8'hFF; i++;
      end
      commit_i = spec_m.size() > 0 && com_m.size() < 8;
      mem_gnt_i = 1'($urandom);
      cyc(); n++;
    end
    drain();
    push(56'h2000, 64'hAAAABBBB, 8'h0F);
    push(56'h2000, 64'h11112222CCCCDDDD, 8'hFF);
    load(56'h2000, 8'h0F);
    chk("fwd_young_valid", ld_fwd_valid_o, 1);
    chk("fwd_young_data", ld_fwd_data_o, 64'h11112222CCCCDDDD);
    load(56'h2008, 8'h0F);
    chk("fwd_miss", {ld_fwd_valid_o, ld_stall_o}, 0);
    idle(); drain();
    push(56'h3000, 64'h1234, 8'h03);
    load(56'h3000, 8'h0F);
    chk("stall_spec", ld_stall_o, 1);
    chk("stall_spec_nofwd", ld_fwd_valid_o, 0);
    cyc(); idle(); commit_i = 1; cyc(); idle();
    load(56'h3000, 8'h0F);
    chk("stall_commit", ld_stall_o, 1);
    idle(); drain();
    valid_i = 1; paddr_i = 56'h3000; be_i = 8'h03; data_i = 64'h77;
    load(56'h3000, 8'h0F);
    chk("stall_push", ld_stall_o, 1);
    cyc(); idle(); drain();
    n = 0;
    while (com_m.size() < 8 && n < 100) begin
      idle();
      valid_i = 1; paddr_i = 56'h8000 + 56'(8 * n); data_i = 64'(n); be_i = 8'hFF;
      commit_i = spec_m.size() > 0 && com_m.size() < 8;
      cyc(); n++;
    end
    idle();
    @(negedge clk);
    chk("cq_full", commit_ready_o, 0);
    chk("cq_full_addr", mem_addr_o, 56'h8000);
    mem_gnt_i = 1; cyc(); idle();
    @(negedge clk);
    chk("cq_free", commit_ready_o, 1);
    cyc();
    #2 rst = 1;
    #1;
    chk("async_rst_req", mem_req_o, 0);
    chk("async_rst_addr", mem_addr_o, 0);
    chk("async_rst_empty", empty_o, 1);
    #2 rst = 0;
    cyc();
    for (int c = 0; c < 2000; c++) begin
      idle();
      valid_i = ($urandom % 2) == 0;
      paddr_i = 56'h4000 + 56'(8 * $urandom_range(0, 3)) + 56'($urandom_range(0, 7));
      data_i = {$urandom, $urandom};
      be_i = 8'($urandom_range(1, 255));
      size_i = 2'($urandom);
      commit_i = ($urandom % 5) < 2 && spec_m.size() > 0 && com_m.size() < 8;
      flush_i = !commit_i && ($urandom % 20) == 0;
      ld_valid_i = ($urandom % 4) != 0;
      ld_paddr_i = 56'h4000 + 56'(8 * $urandom_range(0, 4));
      ld_be_i = 8'($urandom_range(1, 255));
      mem_gnt_i = ($urandom % 2) == 0;
      cyc();
    end
    idle();
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
